// File: rtl/hdmi_clk_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_clk_pkg
// Shared types and helpers for the HDMI fabric clock-enable generator:
//   state_e     : lock sequencer states
//   stab_width  : width of the lock-stability counter for a given LOCK_STABLE
//   ceil_half   : ceil(d/2), the high-phase length of a divided square wave
// -----------------------------------------------------------------------------
package hdmi_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  // The counter only needs to reach LOCK_STABLE-2 (the release happens on
  // the transition out of that value), so $clog2(LOCK_STABLE) bits always
  // suffice; keep at least one bit so tiny thresholds still elaborate.
  function automatic int stab_width(input int lock_stable);
    if (lock_stable > 2) begin
      return $clog2(lock_stable);
    end else begin
      return 1;
    end
  endfunction

  // High-phase length of a divided square wave: ceil(d/2).
  function automatic int ceil_half(input int d);
    return (d + 1) / 2;
  endfunction

endpackage

// File: rtl/hdmi_clk_div_ch.sv
// -----------------------------------------------------------------------------
// hdmi_clk_div_ch
// One divider channel: counter 0..D-1, ratio latch (updated only at a wrap so
// no runt period is produced), one-cycle phase-slip hold and registered
// clock-enable / square-wave outputs.
// Ports:
//   clk, resetn : fast clock, synchronous active-low reset
//   run         : high while the sequencer is in RUN with lock still present
//   ratio       : requested divide ratio (0 is treated as 1)
//   slip        : one-cycle request to hold the counter for one cycle
//   ce          : one-cycle enable, asserted the cycle after cnt = 0
//   clk_div     : square wave, high the cycle after cnt < ceil(D/2)
// -----------------------------------------------------------------------------
module hdmi_clk_div_ch
  import hdmi_clk_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [DIV_W-1:0] ratio,
  input  logic             slip,
  output logic             ce,
  output logic             clk_div
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             hold_q, hold_d;
  logic             ce_q, ce_d;
  logic             clk_div_q, clk_div_d;
  logic [DIV_W-1:0] ratio_norm_s;
  logic [DIV_W-1:0] half_s;

  // Counter, ratio latch, slip hold and next output values.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    hold_d    = 1'b0;
    ce_d      = 1'b0;
    clk_div_d = 1'b0;

    ratio_norm_s = (ratio == {DIV_W{1'b0}}) ? DIV_W'(1) : ratio;
    half_s       = DIV_W'(ceil_half(int'(div_q)));

    if (!run) begin
      // Outside RUN the ratio tracks the input, so the value present on the
      // RUN-entry edge is the one the first period uses.
      cnt_d = {DIV_W{1'b0}};
      div_d = ratio_norm_s;
    end else begin
      ce_d      = (cnt_q == {DIV_W{1'b0}});
      clk_div_d = (cnt_q < half_s);
      if (slip && !hold_q) begin
        // Hold wins over a coincident wrap; the wrap (and ratio latch)
        // happens one cycle later.
        hold_d = 1'b1;
        cnt_d  = cnt_q;
      end else if (cnt_q == (div_q - DIV_W'(1))) begin
        cnt_d = {DIV_W{1'b0}};
        div_d = ratio_norm_s;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= {DIV_W{1'b0}};
      div_q     <= DIV_W'(1);
      hold_q    <= 1'b0;
      ce_q      <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      ce_q      <= ce_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign ce      = ce_q;
  assign clk_div = clk_div_q;

endmodule

// File: rtl/hdmi_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_clk_div_ctrl
// Lock-gated reset sequencer plus NUM_CH phase-aligned fabric dividers.
// Ports:
//   clk, resetn : fast PLL clock, synchronous active-low reset
//   pll_lock    : PLL lock (asynchronous, synchronised here)
//   div_ratio   : per-channel ratio, channel i at [i*DIV_W +: DIV_W]
//   slip        : per-channel one-cycle phase-slip request
//   ce, clk_div : per-channel enable strobe and square wave
//   locked      : high while running
//   rst_out_n   : downstream synchronous active-low reset
// -----------------------------------------------------------------------------
module hdmi_clk_div_ctrl
  import hdmi_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 4,
  parameter int LOCK_STABLE = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    pll_lock,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH-1:0]       slip,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clk_div,
  output logic                    locked,
  output logic                    rst_out_n
);

  localparam int STAB_W = stab_width(LOCK_STABLE);
  // Release fires on the edge that would move the counter to LOCK_STABLE-1.
  localparam logic [STAB_W-1:0] STAB_LAST =
    (LOCK_STABLE >= 2) ? STAB_W'(LOCK_STABLE - 2) : {STAB_W{1'b0}};

  logic              sync_meta_q;
  logic              lock_s_q;
  state_e            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              locked_q, rst_out_n_q;
  logic              run_s;

  // Sequencer next-state and stability counter.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      WAIT_LOCK: begin
        stab_d = {STAB_W{1'b0}};
        if (lock_s_q) begin
          state_d = (LOCK_STABLE <= 1) ? RUN : STABLE;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          stab_d  = {STAB_W{1'b0}};
        end else if (stab_q == STAB_LAST) begin
          state_d = RUN;
          stab_d  = {STAB_W{1'b0}};
        end else begin
          stab_d  = stab_q + STAB_W'(1);
        end
      end
      RUN: begin
        stab_d = {STAB_W{1'b0}};
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        stab_d  = {STAB_W{1'b0}};
      end
    endcase
  end

  // Gating with lock_s as well as RUN makes a lock loss clear the counters and
  // outputs on the very next edge, not one cycle after the state changes.
  assign run_s = (state_q == RUN) && lock_s_q;

  // Lock synchroniser, sequencer state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      stab_q      <= {STAB_W{1'b0}};
      locked_q    <= 1'b0;
      rst_out_n_q <= 1'b0;
    end else begin
      sync_meta_q <= pll_lock;
      lock_s_q    <= sync_meta_q;
      state_q     <= state_d;
      stab_q      <= stab_d;
      locked_q    <= run_s;
      rst_out_n_q <= run_s;
    end
  end

  assign locked    = locked_q;
  assign rst_out_n = rst_out_n_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hdmi_clk_div_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .run     (run_s),
      .ratio   (div_ratio[i*DIV_W +: DIV_W]),
      .slip    (slip[i]),
      .ce      (ce[i]),
      .clk_div (clk_div[i])
    );
  end

endmodule

// File: tb/tb_hdmi_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdmi_clk_div_ctrl
// Directed bench: lock sequencing, table of per-cycle expected strobes for
// ratio patterns, ratio change, slip and zero/one ratios, then hand-written
// reset, lock-loss and lock-glitch sequences.
// -----------------------------------------------------------------------------
module tb_hdmi_clk_div_ctrl;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 4;
  localparam int LOCK_STABLE = 8;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    pll_lock;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic [NUM_CH-1:0]       slip;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       clk_div;
  logic                    locked;
  logic                    rst_out_n;

  int n_checks = 0;
  int n_fail   = 0;

  hdmi_clk_div_ctrl #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_STABLE (LOCK_STABLE)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pll_lock  (pll_lock),
    .div_ratio (div_ratio),
    .slip      (slip),
    .ce        (ce),
    .clk_div   (clk_div),
    .locked    (locked),
    .rst_out_n (rst_out_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r0;
    logic [3:0] r1;
    logic [1:0] slp;
    logic [1:0] exp_ce;
    logic [1:0] exp_cd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r0, input logic [3:0] r1,
                              input logic [1:0] slp, input logic [1:0] e_ce,
                              input logic [1:0] e_cd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.slp = slp; v.exp_ce = e_ce; v.exp_cd = e_cd;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count cycles from pll_lock rise (driven just after an edge) to locked.
  task automatic wait_locked(input string name);
    int got;
    got = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (locked === 1'b1) begin
        got = i;
        break;
      end
    end
    check({name, "_latency"}, 32'(got), 32'd11);
    check({name, "_outputs"}, 32'({rst_out_n, ce, clk_div}), 32'b11111);
  endtask

  initial begin
    // {ratio0, ratio1, slip, exp ce {ch1,ch0}, exp clk_div {ch1,ch0}}
    // ratios 5 / 2
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b10);
    add(4'd5, 4'd2, 2'b00, 2'b01, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b10);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd5, 4'd2, 2'b00, 2'b11, 2'b11);
    // ratio0 -> 3 mid-period: current 5-period completes, then 1,1,0
    add(4'd3, 4'd2, 2'b00, 2'b00, 2'b01);
    add(4'd3, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd3, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd3, 4'd2, 2'b00, 2'b10, 2'b10);
    add(4'd3, 4'd2, 2'b00, 2'b01, 2'b01);
    add(4'd3, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd3, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd3, 4'd2, 2'b00, 2'b11, 2'b11);
    add(4'd3, 4'd2, 2'b00, 2'b00, 2'b01);
    add(4'd3, 4'd2, 2'b00, 2'b10, 2'b10);
    // back to 5, then slip on channel 0 (second pulse in hold is ignored)
    add(4'd5, 4'd2, 2'b00, 2'b01, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd5, 4'd2, 2'b00, 2'b11, 2'b11);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b10);
    add(4'd5, 4'd2, 2'b00, 2'b01, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd5, 4'd2, 2'b01, 2'b00, 2'b01);
    add(4'd5, 4'd2, 2'b01, 2'b10, 2'b11);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b10);
    add(4'd5, 4'd2, 2'b00, 2'b01, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b11);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b01);
    add(4'd5, 4'd2, 2'b00, 2'b10, 2'b10);
    add(4'd5, 4'd2, 2'b00, 2'b00, 2'b00);
    add(4'd5, 4'd2, 2'b00, 2'b11, 2'b11);
    // ratios 0 and 1: constant high once latched at the next wrap
    add(4'd0, 4'd1, 2'b00, 2'b00, 2'b01);
    add(4'd0, 4'd1, 2'b00, 2'b10, 2'b11);
    add(4'd0, 4'd1, 2'b00, 2'b10, 2'b10);
    add(4'd0, 4'd1, 2'b00, 2'b10, 2'b10);
    add(4'd0, 4'd1, 2'b00, 2'b11, 2'b11);
    add(4'd0, 4'd1, 2'b00, 2'b11, 2'b11);
    add(4'd0, 4'd1, 2'b00, 2'b11, 2'b11);

    // Reset state
    resetn    = 1'b0;
    pll_lock  = 1'b0;
    div_ratio = {4'd2, 4'd5};
    slip      = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    check("reset_state", 32'({locked, rst_out_n, ce, clk_div}), 32'd0);

    resetn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("no_lock_idle", 32'({locked, rst_out_n, ce, clk_div}), 32'd0);

    // Lock rise: 2 sync + 8 stable + 1 = 11 cycles, both ce together
    pll_lock = 1'b1;
    wait_locked("lock_rise");

    for (int i = 0; i < vecs.size(); i++) begin
      div_ratio = {vecs[i].r1, vecs[i].r0};
      slip      = vecs[i].slp;
      tick();
      check($sformatf("vec%0d", i + 1),
            32'({locked, rst_out_n, ce, clk_div}),
            32'({2'b11, vecs[i].exp_ce, vecs[i].exp_cd}));
    end
    slip = 2'b00;

    // Reset asserted in RUN: outputs cleared on the next cycle
    resetn = 1'b0;
    tick();
    check("reset_in_run", 32'({locked, rst_out_n, ce, clk_div}), 32'd0);

    // Release with lock held high: full stabilise sequence again
    div_ratio = {4'd2, 4'd5};
    resetn    = 1'b1;
    wait_locked("relock_after_reset");

    // Lock loss mid-period: everything low exactly 3 cycles later
    tick();
    tick();
    pll_lock = 1'b0;
    tick();
    check("drop_t1", 32'({locked, rst_out_n}), 32'b11);
    tick();
    check("drop_t2", 32'({locked, rst_out_n}), 32'b11);
    tick();
    check("drop_t3", 32'({locked, rst_out_n, ce, clk_div}), 32'd0);

    // Short lock pulse inside the stability window must restart the count
    pll_lock = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("glitch_no_release", 32'({locked, rst_out_n}), 32'b00);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_locked("relock_after_glitch");

    // Phase after relock: ch0 ratio 5, ch1 ratio 2 restart aligned
    tick();
    check("post_relock_1", 32'({ce, clk_div}), 32'b0001);
    tick();
    check("post_relock_2", 32'({ce, clk_div}), 32'b1011);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
